// File: rtl/stop_ramp_pkg.sv
// rtl/stop_ramp_pkg.sv - state encoding and stop-code constants for stop_ramp_ctrl (STOP_RAMP_SOFTSTART_EN adds RAMP_UP)
package stop_ramp_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_RAMP_DN = 3'd1,
        ST_STOPPED = 3'd2,
`ifdef STOP_RAMP_SOFTSTART_EN
        ST_ESTOP   = 3'd3,
        ST_RAMP_UP = 3'd4
`else
        ST_ESTOP   = 3'd3
`endif
    } state_e;

    localparam logic [1:0] STOP_RUN   = 2'b00;
    localparam logic [1:0] STOP_SOFT  = 2'b01;
    localparam logic [1:0] STOP_HARD  = 2'b10;
    localparam logic [1:0] STOP_ESTOP = 2'b11;

endpackage

// File: rtl/stop_ramp_tick.sv
// rtl/stop_ramp_tick.sv - ramp tick prescaler, one tick every RAMP_DIV enabled cycles after clr
module stop_ramp_tick #(
    parameter int RAMP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/stop_ramp_ctrl.sv
// rtl/stop_ramp_ctrl.sv - motor stop sequencer (ramp-down, hard stop, latched e-stop); soft start under STOP_RAMP_SOFTSTART_EN
module stop_ramp_ctrl
    import stop_ramp_pkg::*;
#(
    parameter int DW       = 8,
    parameter int STEP     = 16,
    parameter int RAMP_DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    stop_code,
    input  logic [DW-1:0] duty_in,
    input  logic          duty_valid,
    input  logic          estop_ack,
    output logic [DW-1:0] duty_out,
    output logic          motor_en,
    output logic          stopped,
    output logic          estop_latched
);

    localparam logic [DW-1:0] STEP_W = DW'(STEP);

    state_e        state, state_nxt;
    logic [1:0]    code_q;
    logic [DW-1:0] duty_tgt, tgt_nxt, duty_nxt, dn_val, resume_duty;
    logic          tick, tick_clr, tick_en, motor_en_nxt;

    assign tgt_nxt = duty_valid ? duty_in : duty_tgt;
    assign dn_val  = (duty_out > STEP_W) ? duty_out - STEP_W : '0;

`ifdef STOP_RAMP_SOFTSTART_EN
    localparam state_e RESUME_ST = ST_RAMP_UP;
    logic [DW:0]   up_sum;
    logic [DW-1:0] up_val;
    assign up_sum      = {1'b0, duty_out} + {1'b0, STEP_W};
    assign up_val      = (up_sum > {1'b0, duty_tgt}) ? duty_tgt : up_sum[DW-1:0];
    assign resume_duty = duty_out;
`else
    localparam state_e RESUME_ST = ST_RUN;
    assign resume_duty = tgt_nxt;
`endif

    // E-stop is checked ahead of the per-state decode so it wins over ticks and acks
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_out;
        if (code_q == STOP_ESTOP) begin
            state_nxt = ST_ESTOP;
            duty_nxt  = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (code_q == STOP_SOFT) begin
                        state_nxt = ST_RAMP_DN;
                    end else if (code_q == STOP_HARD) begin
                        state_nxt = ST_STOPPED;
                        duty_nxt  = '0;
                    end else begin
                        duty_nxt = tgt_nxt;
                    end
                end
                ST_RAMP_DN: begin
                    if (code_q == STOP_HARD) begin
                        state_nxt = ST_STOPPED;
                        duty_nxt  = '0;
                    end else if (code_q == STOP_RUN) begin
                        state_nxt = RESUME_ST;
                        duty_nxt  = resume_duty;
                    end else if (tick) begin
                        duty_nxt = dn_val;
                        if (dn_val == '0) state_nxt = ST_STOPPED;
                    end
                end
                ST_STOPPED: begin
                    duty_nxt = '0;
                    if (code_q == STOP_RUN) begin
                        state_nxt = RESUME_ST;
                        duty_nxt  = resume_duty;
                    end
                end
                ST_ESTOP: begin
                    duty_nxt = '0;
                    if (estop_ack) state_nxt = ST_STOPPED;
                end
`ifdef STOP_RAMP_SOFTSTART_EN
                ST_RAMP_UP: begin
                    if (code_q == STOP_SOFT) begin
                        state_nxt = ST_RAMP_DN;
                    end else if (code_q == STOP_HARD) begin
                        state_nxt = ST_STOPPED;
                        duty_nxt  = '0;
                    end else if (tick) begin
                        duty_nxt = up_val;
                        if (up_val == duty_tgt) state_nxt = ST_RUN;
                    end
                end
`endif
                default: begin
                    state_nxt = ST_STOPPED;
                    duty_nxt  = '0;
                end
            endcase
        end
    end

    assign motor_en_nxt = !((state_nxt == ST_STOPPED) || (state_nxt == ST_ESTOP));
    assign tick_clr     = (state_nxt != state);
    assign tick_en      = !((state == ST_RUN) || (state == ST_STOPPED) || (state == ST_ESTOP));

    stop_ramp_tick #(
        .RAMP_DIV (RAMP_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_STOPPED;
            code_q        <= STOP_RUN;
            duty_tgt      <= '0;
            duty_out      <= '0;
            motor_en      <= 1'b0;
            stopped       <= 1'b1;
            estop_latched <= 1'b0;
        end else begin
            state         <= state_nxt;
            code_q        <= stop_code;
            duty_tgt      <= tgt_nxt;
            duty_out      <= duty_nxt;
            motor_en      <= motor_en_nxt;
            stopped       <= (duty_nxt == '0) && (state_nxt != ST_RUN);
            estop_latched <= (state_nxt == ST_ESTOP);
        end
    end

endmodule

// File: doc/stop_ramp_ctrl.md
# stop_ramp_ctrl

Motor-drive stop sequencer downstream of the 2-bit STOP GPIO register in the vision/drive Qsys system. Consumes the stop code the Nios writes to the GPIO, together with the requested drive duty, and produces the gated duty and enable actually applied to the motor PWM stage. It supports controlled ramp-down, immediate stop and a latched emergency stop.

## Interface
- `DW`, 8: duty width in bits.
- `STEP`, 16: duty decrement/increment per ramp tick; must satisfy 1 ≤ STEP < 2^DW.
- `RAMP_DIV`, 4: clock cycles per ramp tick; must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `stop_code` in 2: from the GPIO out_port.
  - 00 run, 01 soft stop, 10 hard stop, 11 e-stop.
- `duty_in` in DW: requested drive duty.
- `duty_valid` in 1: capture `duty_in` into the target register this cycle.
- `estop_ack` in 1: single-cycle pulse that releases a latched e-stop.
- `duty_out` out DW: duty applied to the PWM.
- `motor_en` out 1: motor driver enable.
- `stopped` out 1: high when `duty_out == 0` and the block is not in RUN.
- `estop_latched` out 1: high while in ESTOP.

## Operation
- The input `stop_code` is registered once into `code_q`. All decisions use `code_q`.
- Target register `duty_tgt` loads `duty_in` on `duty_valid`, in every state.
- States:
  - RUN: `duty_out` follows `duty_tgt`. `motor_en` = 1.
    - `code_q`=01 → RAMP_DN.
    - `code_q`=10 → STOPPED.
    - `code_q`=11 → ESTOP.
  - RAMP_DN: on each tick, `duty_out` ← `duty_out` > STEP ? `duty_out` − STEP : 0. Saturating; never wraps.
    - On reaching 0 → STOPPED.
    - `code_q`=10 → STOPPED immediately, with `duty_out` ← 0.
    - `code_q`=00 → RUN (or RAMP_UP).
  - STOPPED: `duty_out` = 0. `motor_en` = 0.
    - `code_q`=00 → RUN (or RAMP_UP).
    - 01 and 10 hold in STOPPED.
  - ESTOP: `duty_out` = 0. `motor_en` = 0. Entered from any state when `code_q`=11; 11 has priority over every other event.
    - Exits to STOPPED only when `estop_ack`=1 and `code_q`≠11 in the same cycle. An ack while 11 is ignored.
  - RAMP_UP: exists only with the macro (see Configuration). On each tick, `duty_out` ← min(`duty_out` + STEP, `duty_tgt`), computed in DW+1 bits so it cannot overflow.
    - Reaching `duty_tgt` → RUN.
    - 01 → RAMP_DN from the current value.
    - 10 → STOPPED.
- If `duty_tgt` falls below `duty_out` during RAMP_UP, `duty_out` clamps to `duty_tgt` on the next tick.
- Reset values:
  - state = STOPPED
  - `duty_out` = 0, `motor_en` = 0
  - `stopped` = 1, `estop_latched` = 0
  - `code_q` = 00, `duty_tgt` = 0
  - tick counter = 0

## Timing
- `stop_code` to state change: 2 cycles. One cycle registers into `code_q`; the state and outputs register on the next.
- Hard stop and e-stop: `duty_out` = 0 and `motor_en` = 0 two cycles after the code is applied.
- Tick prescaler:
  - Clears on entry to RAMP_DN or RAMP_UP.
  - The first tick occurs RAMP_DIV cycles after entry, then every RAMP_DIV cycles.
  - It does not count in RUN, STOPPED or ESTOP.
- Soft-stop duration from duty D: ceil(D/STEP) ticks.
- In RUN, `duty_out` updates the cycle after `duty_valid`.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset asserted mid-ramp forces the reset values immediately (asynchronous). Release is synchronous to `clk`.

## Configuration
- `STOP_RAMP_SOFTSTART_EN`
  - Defined: exit from RAMP_DN or STOPPED on 00 goes to RAMP_UP, starting from the current `duty_out`.
  - Undefined: RAMP_UP state and logic are absent. Exit goes directly to RUN, and `duty_out` jumps to `duty_tgt` on the next cycle.

## Structure
- Package `stop_ramp_pkg`:
  - state enum
  - stop-code constants (`STOP_RUN`, `STOP_SOFT`, `STOP_HARD`, `STOP_ESTOP`)
- Sub-module `stop_ramp_tick`: RAMP_DIV prescaler with `clr` and `en` inputs and a `tick` output.

## Test plan
Parameters: DW=8, STEP=16, RAMP_DIV=4.
- Soft ramp: RUN with `duty_tgt`=100, `stop_code`=01 → `duty_out` 84, 68, 52, 36, 20, 4, 0, one step every 4 cycles, first at cycle 6. STOPPED follows with `stopped`=1 and `motor_en`=0.
- Hard stop mid-ramp: `stop_code`=10 when `duty_out`=52 → `duty_out`=0 and STOPPED 2 cycles later.
- E-stop latch:
  - 11 from RUN (`duty_tgt`=200) → `estop_latched`=1 and `duty_out`=0 at cycle 2.
  - `estop_ack` while the code is 11 → still latched.
  - Code changed to 00, then `estop_ack` → STOPPED, then RUN or RAMP_UP.
- Resume:
  - With macro: `duty_tgt`=40, code 00 from STOPPED → `duty_out` 16, 32, 40, then RUN.
  - Without macro: `duty_out`=40 two cycles after the code change.
- Saturation: `duty_tgt`=250 with the macro, ramp up → values 240, then 250. No wrap past 255.
- Async reset mid-ramp (`duty_out`=68) → `duty_out`=0, `motor_en`=0, `stopped`=1 in the same cycle reset asserts.
